// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Single outstanding request: req/addr until gnt, then one in-order rvalid/rdata.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus, and feeds
// id_stage through the IF/ID register with a one-entry skid and redirect kill.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    if_stage_if.master        imem,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc,
    output logic              inst_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] fetch_pc_q;
    logic        kill_q;
    logic [31:0] skid_q;
    logic [31:0] skid_pc_q;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic        valid_q;

    logic [31:0] redir_pc;
    logic        consume;

    assign redir_pc = {redirect_pc[31:2], 2'b00};
    assign consume  = valid_q & ~stall;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign inst_valid     = valid_q;

    // Outputs are registered: every transition into REQ loads req/addr together
    // with the state, so the address is presented the cycle after the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            fetch_pc_q <= '0;
            kill_q     <= 1'b0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            inst_q     <= NOP_INST;
            inst_pc_q  <= '0;
            valid_q    <= 1'b0;
        end else if (redirect) begin
            pc_q      <= redir_pc;
            valid_q   <= 1'b0;
            inst_q    <= NOP_INST;
            skid_q    <= '0;
            skid_pc_q <= '0;
            unique case (state_q)
                REQ: begin
                    if (imem.imem_gnt) begin
                        // Granted fetch is for the old path; its response must be dropped.
                        kill_q  <= 1'b1;
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= redir_pc;
                        state_q <= REQ;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        kill_q  <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= redir_pc;
                        state_q <= REQ;
                    end else begin
                        kill_q  <= 1'b1;
                    end
                end
                default: begin
                    req_q   <= 1'b1;
                    addr_q  <= redir_pc;
                    state_q <= REQ;
                end
            endcase
        end else begin
            if (consume) begin
                valid_q <= 1'b0;
                inst_q  <= NOP_INST;
            end
            unique case (state_q)
                IDLE: begin
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                    state_q <= REQ;
                end
                REQ: begin
                    if (imem.imem_gnt) begin
                        fetch_pc_q <= pc_q;
                        pc_q       <= pc_q + 32'd4;
                        req_q      <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            req_q   <= 1'b1;
                            addr_q  <= pc_q;
                            state_q <= REQ;
                        end else if (!valid_q || !stall) begin
                            inst_q    <= imem.imem_rdata;
                            inst_pc_q <= fetch_pc_q;
                            valid_q   <= 1'b1;
                            req_q     <= 1'b1;
                            addr_q    <= pc_q;
                            state_q   <= REQ;
                        end else begin
                            skid_q    <= imem.imem_rdata;
                            skid_pc_q <= fetch_pc_q;
                            state_q   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_q    <= skid_q;
                        inst_pc_q <= skid_pc_q;
                        valid_q   <= 1'b1;
                        skid_q    <= '0;
                        skid_pc_q <= '0;
                        req_q     <= 1'b1;
                        addr_q    <= pc_q;
                        state_q   <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: per-cycle vector table plus a hand-written
// reset-during-WAIT / long-latency sequence.
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus.master),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        g;
        logic        rv;
        logic [31:0] data;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] inst;
        logic [31:0] ipc;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic g, input logic rv, input logic [31:0] data,
                       input logic req, input logic [31:0] addr, input logic v,
                       input logic [31:0] ins, input logic [31:0] ipc);
        vec_t x;
        x.st = st; x.rd = rd; x.rpc = rpc; x.g = g; x.rv = rv; x.data = data;
        x.req = req; x.addr = addr; x.v = v; x.inst = ins; x.ipc = ipc;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic g, input logic rv, input logic [31:0] data);
        stall           = st;
        redirect        = rd;
        redirect_pc     = rpc;
        bus.imem_gnt    = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = data;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic v, input logic [31:0] ins, input logic [31:0] ipc);
        chk({tag, " imem_req"}, {31'd0, bus.imem_req}, {31'd0, req});
        if (req) chk({tag, " imem_addr"}, bus.imem_addr, addr);
        chk({tag, " inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
        chk({tag, " inst"}, inst, ins);
        if (v) chk({tag, " inst_pc"}, inst_pc, ipc);
    endtask

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // st rd rpc            g rv data          | req addr          v inst          ipc
        add(0,0,32'h0,         0,0,32'h0,          0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hA000_0001,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h4,          1,32'hA000_0001,32'h0);
        add(0,0,32'h0,         0,1,32'hA000_0002,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h8,          1,32'hA000_0002,32'h4);
        add(0,0,32'h0,         0,1,32'hA000_0003,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         0,0,32'h0,          1,32'hC,          1,32'hA000_0003,32'h8);
        add(0,0,32'h0,         1,0,32'h0,          1,32'hC,          0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hB000_0001,  0,32'h0,          0,NOP,          32'h0);
        // four stall cycles with a second word landing in the skid
        add(1,0,32'h0,         1,0,32'h0,          1,32'h10,         1,32'hB000_0001,32'hC);
        add(1,0,32'h0,         0,1,32'hB000_0002,  0,32'h0,          1,32'hB000_0001,32'hC);
        add(1,0,32'h0,         0,0,32'h0,          0,32'h0,          1,32'hB000_0001,32'hC);
        add(1,0,32'h0,         0,0,32'h0,          0,32'h0,          1,32'hB000_0001,32'hC);
        add(0,0,32'h0,         0,0,32'h0,          0,32'h0,          1,32'hB000_0001,32'hC);
        add(0,0,32'h0,         0,0,32'h0,          1,32'h14,         1,32'hB000_0002,32'h10);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h14,         0,NOP,          32'h0);
        // redirect in WAIT, stale response dropped
        add(0,1,32'h102,       0,0,32'h0,          0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hDEAD_0001,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h100,        0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hC000_0001,  0,32'h0,          0,NOP,          32'h0);
        // redirect with gnt, then redirect with rvalid
        add(0,1,32'h200,       1,0,32'h0,          1,32'h104,        1,32'hC000_0001,32'h100);
        add(0,0,32'h0,         0,1,32'hDEAD_0002,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h200,        0,NOP,          32'h0);
        add(0,1,32'h300,       0,1,32'hDEAD_0003,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'h300,        0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hD000_0001,  0,32'h0,          0,NOP,          32'h0);
        // redirect in HOLD under stall discards the skid word
        add(1,0,32'h0,         1,0,32'h0,          1,32'h304,        1,32'hD000_0001,32'h300);
        add(1,0,32'h0,         0,1,32'hDEAD_0004,  0,32'h0,          1,32'hD000_0001,32'h300);
        add(1,1,32'h400,       0,0,32'h0,          0,32'h0,          1,32'hD000_0001,32'h300);
        add(1,0,32'h0,         0,0,32'h0,          1,32'h400,        0,NOP,          32'h0);
        // PC wrap at the top of the address space
        add(0,1,32'hFFFF_FFFE, 0,0,32'h0,          1,32'h400,        0,NOP,          32'h0);
        add(0,0,32'h0,         1,0,32'h0,          1,32'hFFFF_FFFC,  0,NOP,          32'h0);
        add(0,0,32'h0,         0,1,32'hE000_0001,  0,32'h0,          0,NOP,          32'h0);
        add(0,0,32'h0,         0,0,32'h0,          1,32'h0,          1,32'hE000_0001,32'hFFFF_FFFC);
        add(0,0,32'h0,         0,0,32'h0,          1,32'h0,          0,NOP,          32'h0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("reset imem_addr", bus.imem_addr, RST_PC);
        chk("reset inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("reset inst", inst, NOP);
        chk("reset inst_pc", inst_pc, 32'h0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].st, vecs[i].rd, vecs[i].rpc, vecs[i].g, vecs[i].rv, vecs[i].data);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].v,
                    vecs[i].inst, vecs[i].ipc);
        end

        // Reset while a fetch is outstanding; the late response must be ignored.
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk_out("rst_seq gnt", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_seq async imem_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_seq async imem_addr", bus.imem_addr, RST_PC);
        chk("rst_seq async inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_seq async inst", inst, NOP);
        chk("rst_seq async inst_pc", inst_pc, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 32'h0, 0, 1, 32'hBAD0_0BAD);
        #1;
        chk_out("rst_seq idle", 1'b0, 32'h0, 1'b0, NOP, 32'h0);

        // Restart at RESET_PC with a three-cycle response latency.
        @(negedge clk);
        drive(0, 0, 32'h0, 1, 0, 32'h0);
        #1;
        chk_out("lat gnt", 1'b1, RST_PC, 1'b0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk_out("lat n+1", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        #1;
        chk_out("lat n+2", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 1, 32'hF000_0001);
        #1;
        chk_out("lat n+3", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
        @(negedge clk);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        #1;
        chk_out("lat n+4", 1'b1, RST_PC + 32'd4, 1'b1, 32'hF000_0001, RST_PC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
